// File: rtl/memory_read_responder_if.sv
// Read-request interface: requester drives addr/valid and holds them until ready;
// responder returns data plus a broadcast copy of the served address.
interface memory_read_iface #(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
);
  logic [MEMORY_ADDR_WIDTH-1:0] addr;
  logic                         valid;
  logic                         ready;
  logic [MEMORY_WIDTH-1:0]      data;
  logic [MEMORY_ADDR_WIDTH-1:0] broadcast_addr;
  logic                         broadcast_valid;

  modport in (
    input  addr, valid,
    output ready, data, broadcast_addr, broadcast_valid
  );

  modport out (
    output addr, valid,
    input  ready, data, broadcast_addr, broadcast_valid
  );
endinterface

// File: rtl/memory_read_responder.sv
// Instruction memory read responder: READ_LATENCY cycles capture-to-ready, one-cycle ready pulse.
// Backpressure: requester holds valid/addr until ready; writes are refused (wr_ready=0) while a read is in flight.
module memory_read_responder #(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int READ_LATENCY      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  memory_read_iface.in                 memory,
  input  logic                         wr_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
  input  logic [MEMORY_WIDTH-1:0]      wr_data,
  output logic                         wr_ready,
  output logic [15:0]                  reads_served
);

  localparam int DEPTH = 2 ** MEMORY_ADDR_WIDTH;
  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [2:0]                   lat_cnt;
  logic [2:0]                   lat_cnt_nxt;
  logic                         capture;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_q;
  logic [MEMORY_WIDTH-1:0]      data_q;
  logic [15:0]                  served_q;

  logic                         ram_we;
  logic                         ram_rd_en;
  logic [MEMORY_ADDR_WIDTH-1:0] ram_addr;
  logic [MEMORY_WIDTH-1:0]      ram [0:DEPTH-1];

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    capture     = 1'b0;
    unique case (state)
      IDLE: begin
        // A pending write always wins over a read request in the same cycle.
        if (!wr_valid && memory.valid) begin
          capture     = 1'b1;
          lat_cnt_nxt = LAT_INIT;
          state_nxt   = (READ_LATENCY == 1) ? RESP : READ;
        end
      end
      READ: begin
        lat_cnt_nxt = lat_cnt - 3'd1;
        if (lat_cnt <= 3'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ready  = (state == IDLE) && !rst;
    ram_we    = wr_ready && wr_valid;
    ram_rd_en = !rst && (state_nxt == RESP);
    // Single shared address; the first read uses the live request address when
    // latency is one, otherwise the latched one.
    ram_addr  = addr_q;
    if (ram_we) begin
      ram_addr = wr_addr;
    end else if (capture) begin
      ram_addr = memory.addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      addr_q   <= '0;
      served_q <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      if (capture) begin
        addr_q <= memory.addr;
      end
      if (state == RESP) begin
        served_q <= served_q + 16'd1;
      end
    end
  end

  // Storage is never reset; only the registered read port is.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= wr_data;
    end
    if (rst) begin
      data_q <= '0;
    end else if (ram_rd_en) begin
      data_q <= ram[ram_addr];
    end
  end

  assign memory.ready           = (state == RESP) && !rst;
  assign memory.broadcast_valid = (state == RESP) && !rst;
  assign memory.broadcast_addr  = rst ? '0 : addr_q;
  assign memory.data            = rst ? '0 : data_q;
  assign reads_served           = rst ? '0 : served_q;

endmodule

// File: tb/tb_memory_read_responder.sv
module tb_memory_read_responder;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic [10:0] req_addr;
  logic [2:0]  req_valid;
  logic        wr_ready1, wr_ready2, wr_ready4;
  logic [15:0] served1, served2, served4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] data;
    logic [10:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model [0:2047];

  memory_read_iface #(.MEMORY_WIDTH(16), .MEMORY_ADDR_WIDTH(11)) m1 ();
  memory_read_iface #(.MEMORY_WIDTH(16), .MEMORY_ADDR_WIDTH(11)) m2 ();
  memory_read_iface #(.MEMORY_WIDTH(16), .MEMORY_ADDR_WIDTH(11)) m4 ();

  assign m1.addr  = req_addr;
  assign m2.addr  = req_addr;
  assign m4.addr  = req_addr;
  assign m1.valid = req_valid[0];
  assign m2.valid = req_valid[1];
  assign m4.valid = req_valid[2];

  memory_read_responder #(.MEMORY_WIDTH(16), .MEMORY_ADDR_WIDTH(11), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .memory(m1), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready1), .reads_served(served1)
  );
  memory_read_responder #(.MEMORY_WIDTH(16), .MEMORY_ADDR_WIDTH(11), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .memory(m2), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready2), .reads_served(served2)
  );
  memory_read_responder #(.MEMORY_WIDTH(16), .MEMORY_ADDR_WIDTH(11), .READ_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .memory(m4), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready4), .reads_served(served4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return m1.ready;
      1:       return m2.ready;
      default: return m4.ready;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [10:0] a, input logic [15:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    model[a] = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // Counts rising edges until ready is seen at a falling edge; ends in the ready cycle.
  task automatic wait_ready(input int sel, input int exp_lat, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!rdy(sel) && n < 16);
    chk(tag, n, exp_lat);
  endtask

  // Scoreboard for the latency-2 responder.
  always @(negedge clk) begin
    if (!rst && m2.ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", m2.ready, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("resp_data", m2.data, e.data);
        chk("bcast_addr", m2.broadcast_addr, e.addr);
        chk("bcast_valid", m2.broadcast_valid, 1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    req_addr  = '0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", m2.ready, 1'b0);
    chk("rst_data", m2.data, 16'h0);
    chk("rst_bvalid", m2.broadcast_valid, 1'b0);
    chk("rst_baddr", m2.broadcast_addr, 11'h0);
    chk("rst_wr_ready", wr_ready2, 1'b0);
    chk("rst_served", served2, 16'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wr_ready", wr_ready2, 1'b1);
    tick();

    // Write then read, latency 2
    wr(11'd5, 16'hABCD);
    req_addr     = 11'd5;
    req_valid[1] = 1'b1;
    sb_q.push_back('{data: 16'hABCD, addr: 11'd5});
    wait_ready(1, 2, "lat2_first");
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("ready_one_cycle", m2.ready, 1'b0);
    chk("served_after_1", served2, 16'd1);
    tick();

    // Simultaneous write and read to the same address
    wr_valid     = 1'b1;
    wr_addr      = 11'd7;
    wr_data      = 16'h1111;
    model[7]     = 16'h1111;
    req_addr     = 11'd7;
    req_valid[1] = 1'b1;
    sb_q.push_back('{data: 16'h1111, addr: 11'd7});
    @(negedge clk);
    chk("wr_wins_ready", wr_ready2, 1'b1);
    tick();
    wr_valid = 1'b0;
    wait_ready(1, 2, "wr_then_rd_lat");
    req_valid[1] = 1'b0;
    tick();

    // Address changes after capture are ignored
    wr(11'd3, 16'h3333);
    wr(11'd9, 16'h9999);
    req_addr     = 11'd3;
    req_valid[1] = 1'b1;
    sb_q.push_back('{data: 16'h3333, addr: 11'd3});
    tick();
    req_addr = 11'd9;
    @(negedge clk);
    chk("wr_ready_in_read", wr_ready2, 1'b0);
    wait_ready(1, 1, "addr_change_lat");
    req_valid[1] = 1'b0;
    tick();

    // Four back-to-back requests with valid held high
    for (int k = 0; k < 4; k++) wr(11'(20 + k), 16'(16'hA000 + k * 16'h0101));
    req_valid[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr = 11'(20 + k);
      sb_q.push_back('{data: model[20 + k], addr: 11'(20 + k)});
      wait_ready(1, (k == 0) ? 2 : 3, "b2b_spacing");
    end
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("served_after_b2b", served2, 16'd7);
    chk("sb_drained", sb_q.size(), 32'd0);
    tick();

    // Reset one cycle after capture aborts the read
    req_addr     = 11'd5;
    req_valid[1] = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", m2.ready, 1'b0);
    chk("abort_data", m2.data, 16'h0);
    chk("abort_bvalid", m2.broadcast_valid, 1'b0);
    chk("abort_wr_ready", wr_ready2, 1'b0);
    tick();
    rst          = 1'b0;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("abort_wr_ready_back", wr_ready2, 1'b1);
    chk("abort_served", served2, 16'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_ready", m2.ready, 1'b0);
    end
    tick();
    req_addr     = 11'd5;
    req_valid[1] = 1'b1;
    sb_q.push_back('{data: 16'hABCD, addr: 11'd5});
    wait_ready(1, 2, "post_abort_lat");
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_abort_served", served2, 16'd1);
    tick();

    // Latency 1 and latency 4 responders
    req_addr     = 11'd5;
    req_valid[0] = 1'b1;
    wait_ready(0, 1, "lat1");
    chk("lat1_data", m1.data, 16'hABCD);
    chk("lat1_baddr", m1.broadcast_addr, 11'd5);
    chk("lat1_bvalid", m1.broadcast_valid, 1'b1);
    req_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("lat1_served", served1, 16'd1);
    tick();

    req_addr     = 11'd7;
    req_valid[2] = 1'b1;
    wait_ready(2, 4, "lat4");
    chk("lat4_data", m4.data, 16'h1111);
    chk("lat4_baddr", m4.broadcast_addr, 11'd7);
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("lat4_ready_drop", m4.ready, 1'b0);
    chk("lat4_served", served4, 16'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
